// File: rtl/adder_bist_ctrl.sv
// ============================================================================
//  Module   : adder_bist_ctrl
//  Brief    : Self-test controller for half/full adder blocks. Sweeps every
//             {a,b} operand pair into an adder under test, compares the
//             returned {carry,sum} against a+b and reports pass/fail, the
//             mismatch count and the first failing operand pair.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_bist_ctrl #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1     // cycles a/b are held before sampling, 1..15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               abort_i,
    output logic [WIDTH-1:0]   a_o,
    output logic [WIDTH-1:0]   b_o,
    input  logic [WIDTH-1:0]   sum_i,
    input  logic               carry_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [2*WIDTH:0]   err_count_o,
    output logic [WIDTH-1:0]   fail_a_o,
    output logic [WIDTH-1:0]   fail_b_o
);

    localparam int             VW        = 2 * WIDTH;
    localparam logic [VW-1:0]  V_LAST    = '1;
    localparam logic [3:0]     SETTLE_M1 = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   v_q, v_d;           // vector index, {a,b} = v
    logic [3:0]      wait_q, wait_d;     // settle cycles spent in APPLY
    logic [VW:0]     err_q, err_d;
    logic [WIDTH-1:0] fail_a_q, fail_a_d;
    logic [WIDTH-1:0] fail_b_q, fail_b_d;

    logic [WIDTH:0]  w_expect;
    logic            w_match;
    logic            w_mismatch;

    assign a_o      = v_q[VW-1:WIDTH];
    assign b_o      = v_q[WIDTH-1:0];
    assign w_expect = {1'b0, a_o} + {1'b0, b_o};
    assign w_match  = ({carry_i, sum_i} == w_expect);

    // Mismatch unless the compare is a clean 1, so X/Z responses count as failures
    always_comb begin
        w_mismatch = 1'b1;
        if (w_match) begin
            w_mismatch = 1'b0;
        end
    end

    // Next-state logic: sweep sequencing, abort handling and result capture
    always_comb begin
        state_d  = state_q;
        v_d      = v_q;
        wait_d   = wait_q;
        err_d    = err_q;
        fail_a_d = fail_a_q;
        fail_b_d = fail_b_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d  = S_APPLY;
                    v_d      = '0;
                    wait_d   = '0;
                    err_d    = '0;
                    fail_a_d = '0;
                    fail_b_d = '0;
                end
            end
            S_APPLY: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    v_d     = '0;
                    wait_d  = '0;
                end else if (wait_q == SETTLE_M1) begin
                    state_d = S_CHECK;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_CHECK: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    v_d     = '0;
                end else begin
                    if (w_mismatch) begin
                        err_d = err_q + 1'b1;
                        if (err_q == '0) begin
                            fail_a_d = a_o;
                            fail_b_d = b_o;
                        end
                    end
                    // The last vector ends the sweep without wrapping the index
                    if (v_q == V_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_APPLY;
                        v_d     = v_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (start_i && abort_i) begin
                    state_d = S_IDLE;
                end else if (start_i) begin
                    state_d  = S_APPLY;
                    v_d      = '0;
                    wait_d   = '0;
                    err_d    = '0;
                    fail_a_d = '0;
                    fail_b_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            v_q      <= '0;
            wait_q   <= '0;
            err_q    <= '0;
            fail_a_q <= '0;
            fail_b_q <= '0;
        end else begin
            state_q  <= state_d;
            v_q      <= v_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
            fail_a_q <= fail_a_d;
            fail_b_q <= fail_b_d;
        end
    end

    assign busy_o      = (state_q == S_APPLY) || (state_q == S_CHECK);
    assign done_o      = (state_q == S_DONE);
    assign pass_o      = done_o && (err_q == '0);
    assign err_count_o = err_q;
    assign fail_a_o    = fail_a_q;
    assign fail_b_o    = fail_b_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_bist_ctrl.sv
// ============================================================================
//  Module   : tb_adder_bist_ctrl
//  Brief    : Bench for adder_bist_ctrl. Two controllers (1-bit/SETTLE 1 and
//             2-bit/SETTLE 3) drive behavioural adders with selectable faults;
//             results are compared with a vector-list reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adder_bist_ctrl;

    localparam int O_A = 0, O_B = 1, O_BUSY = 2, O_DONE = 3, O_PASS = 4,
                   O_ERR = 5, O_FA = 6, O_FB = 7;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] start_i;
    logic [1:0] abort_i;

    logic [0:0] a1, b1, sum1, fa1, fb1;
    logic       carry1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [1:0] a2, b2, sum2, fa2, fb2;
    logic       carry2, busy2, done2, pass2;
    logic [4:0] err2;

    // Fault model: 0 good, 1 carry stuck-0, 2 sum=a|b, 3 random flip table, 4 X on one vector
    int         mode [2];
    logic [8:0] flip [2][16];
    int         xv   [2];
    logic [8:0] r1, r2;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    adder_bist_ctrl #(.WIDTH(1), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i[0]), .abort_i(abort_i[0]),
        .a_o(a1), .b_o(b1), .sum_i(sum1), .carry_i(carry1),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(err1),
        .fail_a_o(fa1), .fail_b_o(fb1)
    );

    adder_bist_ctrl #(.WIDTH(2), .SETTLE(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i[1]), .abort_i(abort_i[1]),
        .a_o(a2), .b_o(b2), .sum_i(sum2), .carry_i(carry2),
        .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_count_o(err2),
        .fail_a_o(fa2), .fail_b_o(fb2)
    );

    function automatic logic [8:0] aut_resp(input int i, input int a, input int b);
        int         w;
        int         v;
        logic [8:0] c;
        logic [8:0] r;
        w = (i == 0) ? 1 : 2;
        v = (a << w) | b;
        c = 9'(a + b);
        case (mode[i])
            1:       r = c & ~(9'd1 << w);
            2:       r = (c & (9'd1 << w)) | 9'(a | b);
            3:       r = c ^ flip[i][v];
            4:       r = (v == xv[i]) ? 9'bx : c;
            default: r = c;
        endcase
        return r;
    endfunction

    // Behavioural adders under test; also re-evaluated on clk so a fault-mode change is seen
    always @(a1 or b1 or clk) r1 = aut_resp(0, int'(a1), int'(b1));
    always @(a2 or b2 or clk) r2 = aut_resp(1, int'(a2), int'(b2));
    assign sum1   = r1[0:0];
    assign carry1 = r1[1];
    assign sum2   = r2[1:0];
    assign carry2 = r2[2];

    function automatic logic [31:0] get(input int i, input int sel);
        logic [31:0] r;
        r = '0;
        if (i == 0) begin
            case (sel)
                O_A: r = 32'(a1);      O_B: r = 32'(b1);
                O_BUSY: r = 32'(busy1); O_DONE: r = 32'(done1);
                O_PASS: r = 32'(pass1); O_ERR: r = 32'(err1);
                O_FA: r = 32'(fa1);    default: r = 32'(fb1);
            endcase
        end else begin
            case (sel)
                O_A: r = 32'(a2);      O_B: r = 32'(b2);
                O_BUSY: r = 32'(busy2); O_DONE: r = 32'(done2);
                O_PASS: r = 32'(pass2); O_ERR: r = 32'(err2);
                O_FA: r = 32'(fa2);    default: r = 32'(fb2);
            endcase
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk vectors 0..upto-1, count those whose response differs from a+b
    task automatic ref_sweep(input int i, input int upto, output int ec, output int fa, output int fb);
        int         w;
        logic [8:0] m;
        logic [8:0] r;
        w  = (i == 0) ? 1 : 2;
        m  = 9'((1 << (w + 1)) - 1);
        ec = 0; fa = 0; fb = 0;
        for (int v = 0; v < upto; v++) begin
            int a, b;
            a = v >> w;
            b = v & ((1 << w) - 1);
            r = aut_resp(i, a, b) & m;
            if (r !== 9'(a + b)) begin
                if (ec == 0) begin
                    fa = a;
                    fb = b;
                end
                ec++;
            end
        end
    endtask

    task automatic check_idle_zero(input int i, input string tag);
        check_eq({tag, "_a"},    get(i, O_A), 0);
        check_eq({tag, "_b"},    get(i, O_B), 0);
        check_eq({tag, "_busy"}, get(i, O_BUSY), 0);
        check_eq({tag, "_done"}, get(i, O_DONE), 0);
        check_eq({tag, "_pass"}, get(i, O_PASS), 0);
        check_eq({tag, "_err"},  get(i, O_ERR), 0);
        check_eq({tag, "_fa"},   get(i, O_FA), 0);
        check_eq({tag, "_fb"},   get(i, O_FB), 0);
    endtask

    // Pulse start, follow every cycle of the sweep, then check the final report
    task automatic run_sweep(input int i, input int md, input bit rand_start);
        int w, s, n, ec, fa, fb;
        w = (i == 0) ? 1 : 2;
        s = (i == 0) ? 1 : 3;
        n = 1 << (2 * w);
        mode[i] = md;
        @(negedge clk); start_i[i] = 1'b1;
        @(negedge clk); start_i[i] = 1'b0;
        for (int k = 0; k < n * (s + 1); k++) begin
            int v;
            v = k / (s + 1);
            check_eq("sweep_a",    get(i, O_A), v >> w);
            check_eq("sweep_b",    get(i, O_B), v & ((1 << w) - 1));
            check_eq("sweep_busy", get(i, O_BUSY), 1);
            check_eq("sweep_done", get(i, O_DONE), 0);
            if (k == 0) check_eq("err_cleared", get(i, O_ERR), 0);
            start_i[i] = rand_start ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
        end
        start_i[i] = 1'b0;
        ref_sweep(i, n, ec, fa, fb);
        check_eq("end_done", get(i, O_DONE), 1);
        check_eq("end_busy", get(i, O_BUSY), 0);
        check_eq("end_pass", get(i, O_PASS), (ec == 0) ? 1 : 0);
        check_eq("end_err",  get(i, O_ERR), ec);
        check_eq("end_a",    get(i, O_A), (1 << w) - 1);
        check_eq("end_b",    get(i, O_B), (1 << w) - 1);
        if (ec != 0) begin
            check_eq("end_fail_a", get(i, O_FA), fa);
            check_eq("end_fail_b", get(i, O_FB), fb);
        end
    endtask

    // Abort in the first APPLY cycle of vector av, then try start+abort from IDLE
    task automatic abort_test(input int i, input int md, input int av);
        int s, ec, fa, fb;
        s = (i == 0) ? 1 : 3;
        mode[i] = md;
        @(negedge clk); start_i[i] = 1'b1;
        @(negedge clk); start_i[i] = 1'b0;
        repeat (av * (s + 1)) @(negedge clk);
        abort_i[i] = 1'b1;
        @(negedge clk); abort_i[i] = 1'b0;
        ref_sweep(i, av, ec, fa, fb);
        check_eq("abort_busy", get(i, O_BUSY), 0);
        check_eq("abort_done", get(i, O_DONE), 0);
        check_eq("abort_a",    get(i, O_A), 0);
        check_eq("abort_b",    get(i, O_B), 0);
        check_eq("abort_err",  get(i, O_ERR), ec);
        if (ec != 0) begin
            check_eq("abort_fail_a", get(i, O_FA), fa);
            check_eq("abort_fail_b", get(i, O_FB), fb);
        end
        start_i[i] = 1'b1; abort_i[i] = 1'b1;
        @(negedge clk); start_i[i] = 1'b0; abort_i[i] = 1'b0;
        check_eq("idle_sa_busy", get(i, O_BUSY), 0);
        check_eq("idle_sa_err",  get(i, O_ERR), ec);
        @(negedge clk);
        check_eq("idle_sa_busy2", get(i, O_BUSY), 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_i = '0;
        abort_i = '0;
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0;
            xv[i]   = 0;
            for (int v = 0; v < 16; v++) flip[i][v] = '0;
        end
        #12;
        check_idle_zero(0, "rst1");
        check_idle_zero(1, "rst2");
        @(negedge clk); rst_n = 1'b1;

        // Good half adder, then carry stuck-0, then sum=a|b, then good rerun from DONE
        run_sweep(0, 0, 1'b0);
        run_sweep(0, 1, 1'b0);
        run_sweep(0, 2, 1'b0);
        run_sweep(0, 0, 1'b0);

        // start+abort together from DONE returns to IDLE with done cleared
        @(negedge clk); start_i[0] = 1'b1; abort_i[0] = 1'b1;
        @(negedge clk); start_i[0] = 1'b0; abort_i[0] = 1'b0;
        check_eq("done_sa_done", get(0, O_DONE), 0);
        check_eq("done_sa_busy", get(0, O_BUSY), 0);

        // Abort during vector 10 of the 1-bit sweep
        abort_test(0, 1, 2);

        // Asynchronous reset during vector 01, then a full sweep
        mode[0] = 0;
        @(negedge clk); start_i[0] = 1'b1;
        @(negedge clk); start_i[0] = 1'b0;
        @(negedge clk); @(negedge clk);
        check_eq("pre_rst_a", get(0, O_B), 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_zero(0, "midrst");
        @(negedge clk); rst_n = 1'b1;
        run_sweep(0, 0, 1'b0);

        // 2-bit adder, SETTLE 3: good, then carry dropped, then abort with partial count
        run_sweep(1, 0, 1'b0);
        run_sweep(1, 1, 1'b0);
        abort_test(1, 1, $urandom_range(8, 15));

        // Randomised fault patterns and stray start pulses while busy
        for (int t = 0; t < 8; t++) begin
            int i, w, n, md;
            i  = $urandom_range(0, 1);
            w  = (i == 0) ? 1 : 2;
            n  = 1 << (2 * w);
            md = $urandom_range(0, 4);
            for (int v = 0; v < 16; v++) begin
                flip[i][v] = ($urandom_range(0, 3) == 0) ?
                             9'($urandom_range(1, (1 << (w + 1)) - 1)) : 9'd0;
            end
            xv[i] = $urandom_range(0, n - 1);
            run_sweep(i, md, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
